rej_uniform_sampler: RTL
========================

# rej_uniform_sampler

Rejection sampler that turns the SHAKE128 output string of `sponge_const` into one uniform polynomial of the Kyber public matrix Â. It sits directly downstream of `sponge_const`: it latches the 5376-bit (672-byte) squeeze output when the sponge reports `done`. It then walks the bytes three at a time, producing two 12-bit candidates per cycle and keeping those below q = 3329, until 256 coefficients are collected. The filled polynomial goes to the NTT-domain matrix storage.

## Interface
Parameters:
- `IN_BITS`, 5376, width of the sponge output string (672 bytes, 224 byte-triples)
- `N`, 256, coefficients per polynomial
- `Q`, 3329, modulus and rejection bound

Ports:
- `clk`  in  1  single clock, rising-edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin sampling; sampled only in IDLE or DONE
- `in`  in  IN_BITS  sponge output string; byte k = `in[8k+7:8k]`
- `in_valid`  in  1  sponge `done`; `start` is ignored unless `in_valid`=1
- `poly_out`  out  N*12  coefficient i = `poly_out[12i+11:12i]`
- `busy`  out  1  high in SAMPLE
- `done`  out  1  high in DONE
- `fail`  out  1  high in DONE when the input was exhausted before N coefficients were accepted

## Operation
- States: IDLE, SAMPLE, DONE.
- Registers:
  - `buf` (IN_BITS)
  - `t`, triple index, 8 bits, 0..223
  - `cnt`, accepted count, 9 bits, 0..256
  - `poly` (N*12)
- IDLE/DONE with `start`=1 and `in_valid`=1:
  - `buf`←`in`, `t`←0, `cnt`←0, `poly`←0, `fail`←0.
  - Go to SAMPLE.
- `start` with `in_valid`=0: ignored, state unchanged.
- SAMPLE, each cycle, with b0,b1,b2 = bytes 3t, 3t+1, 3t+2 of `buf`:
  - d1 = b0 + 256·(b1 & 0xF)
  - d2 = (b1 >> 4) + 16·b2
  - Both are 12-bit, range 0..4095.
- Acceptance:
  - d1 is accepted iff d1 < Q and `cnt` < N; it is written to `poly[cnt]`.
  - d2 is accepted iff d2 < Q and (`cnt` + acc1) < N; it is written to the next free slot.
  - `cnt` advances by 0, 1 or 2.
  - When only one slot remains and both candidates are valid, d1 is kept and d2 is discarded.
- Transitions out of SAMPLE:
  - If the new `cnt` = N: go to DONE, `fail`=0.
  - Else if `t` = 223: go to DONE, `fail`=1. `poly` keeps the partial coefficients; unwritten slots stay 0.
  - Otherwise `t`←`t`+1.
- DONE:
  - Outputs are held stable until the next accepted `start`.
  - `start` in DONE restarts immediately, with no pass through IDLE.
- `start` during SAMPLE is ignored.
- Reset (asynchronous, any state):
  - State→IDLE.
  - `busy`=0, `done`=0, `fail`=0, `poly_out`=0, `t`=0, `cnt`=0.
  - Reset in the middle of a run discards all progress; no partial `done` is ever asserted.
- Arithmetic:
  - The comparison against Q is unsigned, 12-bit.
  - `cnt` never exceeds N.
  - `t` never exceeds 223.

## Timing
- Start edge E0 (`start`·`in_valid`·(IDLE|DONE)): `busy`=1 after E0. Triple 0 is processed at edge E1, triple k at E(k+1).
- Latency from E0 to `done`=1:
  - Minimum: 128 edges (every candidate accepted).
  - Maximum: 224 edges (input exhausted).
- `done` rises on the same edge on which `busy` falls.
- `poly_out` is valid whenever `done`=1. During SAMPLE it changes each cycle and must not be consumed.
- `in` is sampled only at E0. The upstream sponge may change `in` afterwards.

## Test plan
- All-zero `in`, start:
  - Every d1/d2 = 0 is accepted.
  - `done`=1 exactly 128 cycles after the start edge, `fail`=0, `poly_out`=0.
- `in` all 0xFF:
  - d1 = d2 = 4095, all rejected.
  - `done`=1 after 224 cycles, `fail`=1, `poly_out`=0.
- Bound check, triple 0 bytes {00,0D,D0}, remaining bytes 0:
  - d1 = 3328 is accepted.
  - d2 = 0xD00 = 3328 is accepted.
  - Repeat with {01,0D,D0}: d1 = 3329 is rejected; d2 = 0xD00 = 3328 is accepted into slot 0.
- Overshoot:
  - Triples 0..126 are zero (254 coefficients).
  - Triple 127 = {00,F0,FF}: d1 accepted, d2 = 4095 rejected; `cnt` = 255.
  - Triple 128 = zero: d1 fills slot 255, d2 is dropped.
  - `done` after 129 cycles, `fail`=0.
- Reset mid-run:
  - Assert `rst`=0 asynchronously 50 cycles after start.
  - All outputs go to 0 immediately, state is IDLE.
  - A new start then completes normally.
- Integration:
  - Seed f8f11229…c9665598, domain 4'b1111, output_len 5376 from `sponge_const`.
  - Start on its `done`.
  - All 256 coefficients match the software SampleNTT model, `fail`=0.

Source files
------------

// File: rtl/rej_uniform_sampler.sv
// Rejection sampler: turns a SHAKE128 squeeze string into one uniform Kyber
// polynomial by keeping the 12-bit candidates below Q.
module rej_uniform_sampler #(
  parameter int IN_BITS = 5376,
  parameter int N       = 256,
  parameter int Q       = 3329
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IN_BITS-1:0]   in,
  input  logic                 in_valid,
  output logic [N*12-1:0]      poly_out,
  output logic                 busy,
  output logic                 done,
  output logic                 fail
);

  localparam int         TRIPLES = IN_BITS / 24;
  localparam logic [7:0] LAST_T  = 8'(TRIPLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IN_BITS-1:0]   buf_q, buf_d;
  logic [7:0]           t_q, t_d;
  logic [8:0]           cnt_q, cnt_d;
  logic [N*12-1:0]      poly_q, poly_d;
  logic                 fail_q, fail_d;

  logic [7:0]  b0, b1, b2;
  logic [11:0] d1, d2;
  logic        acc1, acc2;
  logic [8:0]  cnt1, cnt2;

  // The buffer shifts down one triple per cycle, so the current triple is
  // always in the low 24 bits instead of needing a 224-way byte mux.
  always_comb begin
    b0   = buf_q[7:0];
    b1   = buf_q[15:8];
    b2   = buf_q[23:16];
    d1   = {b1[3:0], b0};
    d2   = {b2, b1[7:4]};
    acc1 = (d1 < 12'(Q)) && (cnt_q < 9'(N));
    cnt1 = cnt_q + {8'd0, acc1};
    acc2 = (d2 < 12'(Q)) && (cnt1 < 9'(N));
    cnt2 = cnt1 + {8'd0, acc2};
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    poly_d  = poly_q;
    fail_d  = fail_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && in_valid) begin
          buf_d   = in;
          t_d     = 8'd0;
          cnt_d   = 9'd0;
          poly_d  = '0;
          fail_d  = 1'b0;
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        for (int i = 0; i < N; i++) begin
          if (acc1 && (cnt_q == 9'(i))) poly_d[12*i +: 12] = d1;
          if (acc2 && (cnt1 == 9'(i)))  poly_d[12*i +: 12] = d2;
        end
        cnt_d = cnt2;
        if (cnt2 == 9'(N)) begin
          fail_d  = 1'b0;
          state_d = ST_DONE;
        end else if (t_q == LAST_T) begin
          fail_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          t_d   = t_q + 8'd1;
          buf_d = {24'd0, buf_q[IN_BITS-1:24]};
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      t_q     <= 8'd0;
      cnt_q   <= 9'd0;
      poly_q  <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      poly_q  <= poly_d;
      fail_q  <= fail_d;
    end
  end

  assign poly_out = poly_q;
  assign busy     = (state_q == ST_SAMPLE);
  assign done     = (state_q == ST_DONE);
  assign fail     = fail_q;

endmodule
